// File: rtl/fma_arbiter.sv
// Round-robin front end that shares one fma_float unit among N_REQ requesters.
// Captures operands, screens negative inputs, issues one start, and times out a stuck unit.
module fma_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  op_a,
    input  logic [32*N_REQ-1:0]  op_b,
    input  logic [32*N_REQ-1:0]  op_c,
    output logic [N_REQ-1:0]     req_ack,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_result,
    output logic [1:0]           rsp_err,
    output logic                 busy,
    output logic                 fma_start,
    output logic [31:0]          fma_a,
    output logic [31:0]          fma_b,
    output logic [31:0]          fma_c,
    input  logic [31:0]          fma_result,
    input  logic                 fma_done
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned TmrW = $clog2(TIMEOUT);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_REQ - 1);
    localparam logic [TmrW-1:0] TmrMax  = TmrW'(TIMEOUT - 1);
    localparam logic [31:0]     QNan    = 32'h7FC0_0000;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    logic [1:0]      state_q;
    logic [IdxW-1:0] last_grant_q;
    logic [IdxW-1:0] idx_q;
    logic [TmrW-1:0] timer_q;

    logic            grant_valid;
    logic [IdxW-1:0] grant_idx;
    logic [IdxW-1:0] cand;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [31:0]     sel_c;
    logic            neg_op;

    // Scan upward from the requester after the last one served, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IdxW'((32'(last_grant_q) + k) % N_REQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_a  = op_a[32*grant_idx +: 32];
        sel_b  = op_b[32*grant_idx +: 32];
        sel_c  = op_c[32*grant_idx +: 32];
        neg_op = fma_a[31] | fma_b[31] | fma_c[31];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= LastIdx;
            idx_q        <= '0;
            timer_q      <= '0;
            req_ack      <= '0;
            rsp_valid    <= '0;
            rsp_result   <= '0;
            rsp_err      <= '0;
            busy         <= 1'b0;
            fma_start    <= 1'b0;
            fma_a        <= '0;
            fma_b        <= '0;
            fma_c        <= '0;
        end else begin
            req_ack   <= '0;
            rsp_valid <= '0;
            fma_start <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        idx_q              <= grant_idx;
                        fma_a              <= sel_a;
                        fma_b              <= sel_b;
                        fma_c              <= sel_c;
                        req_ack[grant_idx] <= 1'b1;
                        busy               <= 1'b1;
                        state_q            <= StIssue;
                    end
                end
                StIssue: begin
                    // The FMA unit rejects negative operands, so answer those here.
                    if (neg_op) begin
                        rsp_result <= QNan;
                        rsp_err    <= 2'b01;
                        state_q    <= StResp;
                    end else begin
                        fma_start <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (fma_done) begin
                        rsp_result <= fma_result;
                        rsp_err    <= 2'b00;
                        state_q    <= StResp;
                    end else if (timer_q == TmrMax) begin
                        rsp_result <= QNan;
                        rsp_err    <= 2'b10;
                        state_q    <= StResp;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StResp: begin
                    rsp_valid[idx_q] <= 1'b1;
                    last_grant_q     <= idx_q;
                    busy             <= 1'b0;
                    state_q          <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fma_arbiter.sv
// Directed bench for fma_arbiter with a small FMA model answering a fixed table of products.
module tb_fma_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    localparam logic [31:0] F1   = 32'h3F80_0000;  // 1.0
    localparam logic [31:0] F2   = 32'h4000_0000;  // 2.0
    localparam logic [31:0] F3   = 32'h4040_0000;  // 3.0
    localparam logic [31:0] F4   = 32'h4080_0000;  // 4.0
    localparam logic [31:0] F5   = 32'h40A0_0000;  // 5.0
    localparam logic [31:0] F6   = 32'h40C0_0000;  // 6.0
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [32*N-1:0] op_a = '0;
    logic [32*N-1:0] op_b = '0;
    logic [32*N-1:0] op_c = '0;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   rsp_valid;
    logic [31:0]    rsp_result;
    logic [1:0]     rsp_err;
    logic           busy;
    logic           fma_start;
    logic [31:0]    fma_a;
    logic [31:0]    fma_b;
    logic [31:0]    fma_c;
    logic [31:0]    fma_result;
    logic           fma_done;

    int errors = 0;
    int checks = 0;

    fma_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .busy(busy), .fma_start(fma_start), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
        .fma_result(fma_result), .fma_done(fma_done)
    );

    always #5 clk = ~clk;

    // FMA model: 1.0*2.0+c for the c values used here; done_delay=0 means never done.
    int          done_delay = 4;
    logic        stale_req = 1'b0;
    int          start_cnt = 0;
    logic        pending;
    int          cnt;
    logic [31:0] la, lb, lc;

    function automatic logic [31:0] fma_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        logic [31:0] r;
        r = 32'hDEAD_BEEF;
        if (a == F1 && b == F2) begin
            if (c == F1) r = F3;
            else if (c == F2) r = F4;
            else if (c == F3) r = F5;
            else if (c == F4) r = F6;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            cnt        <= 0;
            fma_done   <= 1'b0;
            fma_result <= '0;
        end else begin
            fma_done <= 1'b0;
            if (fma_start) start_cnt <= start_cnt + 1;
            if (stale_req) begin
                fma_done   <= 1'b1;
                fma_result <= 32'h1234_5678;
            end else if (pending) begin
                if (cnt <= 1) begin
                    fma_done   <= 1'b1;
                    fma_result <= fma_ref(la, lb, lc);
                    pending    <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (fma_start && done_delay > 0) begin
                pending <= 1'b1;
                cnt     <= done_delay;
                la      <= fma_a;
                lb      <= fma_b;
                lc      <= fma_c;
            end
        end
    end

    function automatic int oh2idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
        op_a[32*i +: 32] = a;
        op_b[32*i +: 32] = b;
        op_c[32*i +: 32] = c;
    endtask

    task automatic wait_ack(input int max, output int cyc);
        cyc = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (|req_ack) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int max, output int cyc);
        cyc = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (|rsp_valid) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL reset_req_ack: got %b want 0000", req_ack); end
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        checks++; if ({rsp_result, rsp_err} !== 34'b0) begin errors++; $display("FAIL reset_rsp: got %h/%b want 0/00", rsp_result, rsp_err); end
        checks++; if ({busy, fma_start} !== 2'b00) begin errors++; $display("FAIL reset_busy_start: got %b want 00", {busy, fma_start}); end
        checks++; if ({fma_a, fma_b, fma_c} !== 96'b0) begin errors++; $display("FAIL reset_fma_ops: got %h want 0", {fma_a, fma_b, fma_c}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [31:0] cv [4];
        logic [31:0] ev [4];
        int g [5];
        int ri [5];
        logic [31:0] rr [5];
        int ng, nr, s0;
        cv = '{F1, F2, F3, F4};
        ev = '{F3, F4, F5, F6};
        for (int i = 0; i < 5; i++) begin g[i] = -1; ri[i] = -1; rr[i] = '0; end
        for (int i = 0; i < N; i++) set_op(i, F1, F2, cv[i]);
        ng = 0; nr = 0; s0 = start_cnt;
        req = 4'hF;
        for (int k = 0; k < 200 && nr < 5; k++) begin
            @(negedge clk);
            if (|req_ack && ng < 5) begin
                g[ng] = oh2idx(req_ack);
                ng++;
                if (ng == 5) req = '0;
            end
            if (|rsp_valid && nr < 5) begin
                ri[nr] = oh2idx(rsp_valid);
                rr[nr] = rsp_result;
                nr++;
            end
        end
        req = '0;
        @(negedge clk);
        checks++; if (nr != 5) begin errors++; $display("FAIL rr_rsp_count: got %0d want 5", nr); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (g[k] != k % 4) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", k, g[k], k % 4); end
            checks++; if (ri[k] != k % 4) begin errors++; $display("FAIL rr_rsp_idx%0d: got %0d want %0d", k, ri[k], k % 4); end
            checks++; if (rr[k] !== ev[k % 4]) begin errors++; $display("FAIL rr_result%0d: got %h want %h", k, rr[k], ev[k % 4]); end
        end
        checks++; if (start_cnt - s0 != 5) begin errors++; $display("FAIL rr_starts: got %0d want 5", start_cnt - s0); end
    endtask

    task automatic test_single();
        int cyc, s0;
        s0 = start_cnt;
        set_op(0, F1, F2, F3);
        req = 4'b0001;
        wait_ack(4, cyc);
        checks++; if (cyc != 1 || req_ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got cyc=%0d ack=%b want 1/0001", cyc, req_ack); end
        checks++; if ({fma_a, fma_b, fma_c} !== {F1, F2, F3}) begin errors++; $display("FAIL single_ops: got %h want %h", {fma_a, fma_b, fma_c}, {F1, F2, F3}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        req = '0;
        @(negedge clk);
        checks++; if (fma_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", fma_start); end
        wait_rsp(40, cyc);
        checks++; if (cyc != 7) begin errors++; $display("FAIL single_latency: got %0d want 7", cyc); end
        checks++; if (rsp_valid !== 4'b0001 || rsp_result !== F5 || rsp_err !== 2'b00) begin errors++; $display("FAIL single_rsp: got %b/%h/%b want 0001/%h/00", rsp_valid, rsp_result, rsp_err, F5); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy); end
        checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
        @(negedge clk);
        checks++; if (rsp_result !== F5 || rsp_valid !== 4'b0) begin errors++; $display("FAIL single_hold: got %h/%b want %h/0000", rsp_result, rsp_valid, F5); end
    endtask

    task automatic test_reject();
        int cyc, s0;
        s0 = start_cnt;
        set_op(2, 32'hBF80_0000, F2, F2);
        req = 4'b0100;
        wait_ack(4, cyc);
        checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL reject_ack: got %b want 0100", req_ack); end
        req = '0;
        wait_rsp(10, cyc);
        checks++; if (cyc != 2) begin errors++; $display("FAIL reject_latency: got %0d want 2", cyc); end
        checks++; if (rsp_valid !== 4'b0100 || rsp_result !== QNAN || rsp_err !== 2'b01) begin errors++; $display("FAIL reject_rsp: got %b/%h/%b want 0100/%h/01", rsp_valid, rsp_result, rsp_err, QNAN); end
        checks++; if (start_cnt != s0) begin errors++; $display("FAIL reject_no_start: got %0d starts want 0", start_cnt - s0); end
    endtask

    task automatic test_timeout();
        int cyc;
        done_delay = 0;
        set_op(1, F1, F2, F1);
        req = 4'b0010;
        wait_ack(4, cyc);
        req = '0;
        wait_rsp(40, cyc);
        checks++; if (cyc != TO + 2) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", cyc, TO + 2); end
        checks++; if (rsp_valid !== 4'b0010 || rsp_result !== QNAN || rsp_err !== 2'b10) begin errors++; $display("FAIL timeout_rsp: got %b/%h/%b want 0010/%h/10", rsp_valid, rsp_result, rsp_err, QNAN); end
        done_delay = 4;
        set_op(3, F1, F2, F4);
        req = 4'b1000;
        wait_ack(4, cyc);
        req = '0;
        wait_rsp(40, cyc);
        checks++; if (rsp_valid !== 4'b1000 || rsp_result !== F6 || rsp_err !== 2'b00) begin errors++; $display("FAIL after_timeout_rsp: got %b/%h/%b want 1000/%h/00", rsp_valid, rsp_result, rsp_err, F6); end
    endtask

    task automatic test_stale_done();
        int cyc;
        logic quiet;
        stale_req = 1'b1;
        @(negedge clk);
        stale_req = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL stale_quiet: got rsp_valid=%b busy=%b want idle", rsp_valid, busy); end
        set_op(1, F1, F2, F2);
        req = 4'b0010;
        wait_ack(4, cyc);
        req = '0;
        wait_rsp(40, cyc);
        checks++; if (rsp_valid !== 4'b0010 || rsp_result !== F4 || rsp_err !== 2'b00) begin errors++; $display("FAIL stale_rsp: got %b/%h/%b want 0010/%h/00", rsp_valid, rsp_result, rsp_err, F4); end
    endtask

    task automatic test_reset_mid_wait();
        int cyc;
        done_delay = 0;
        set_op(2, F1, F2, F1);
        req = 4'b0100;
        wait_ack(4, cyc);
        req = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_wait_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({req_ack, rsp_valid, busy, fma_start} !== 10'b0) begin errors++; $display("FAIL midrst_ctrl: got %b want 0", {req_ack, rsp_valid, busy, fma_start}); end
        checks++; if ({fma_a, fma_b, fma_c, rsp_result, rsp_err} !== 130'b0) begin errors++; $display("FAIL midrst_data: got %h want 0", {fma_a, fma_b, fma_c, rsp_result, rsp_err}); end
        done_delay = 4;
        set_op(0, F1, F2, F3);
        set_op(3, F1, F2, F2);
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(4, cyc);
        checks++; if (cyc != 1 || req_ack !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant: got cyc=%0d ack=%b want 1/0001", cyc, req_ack); end
        req = 4'b1000;
        wait_rsp(40, cyc);
        checks++; if (rsp_valid !== 4'b0001 || rsp_result !== F5) begin errors++; $display("FAIL midrst_rsp0: got %b/%h want 0001/%h", rsp_valid, rsp_result, F5); end
        wait_ack(4, cyc);
        checks++; if (req_ack !== 4'b1000) begin errors++; $display("FAIL midrst_second_grant: got %b want 1000", req_ack); end
        req = '0;
        wait_rsp(40, cyc);
        checks++; if (rsp_valid !== 4'b1000 || rsp_result !== F4 || rsp_err !== 2'b00) begin errors++; $display("FAIL midrst_rsp3: got %b/%h/%b want 1000/%h/00", rsp_valid, rsp_result, rsp_err, F4); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_reject();
        test_timeout();
        test_stale_done();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
